// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: configuration register
// addresses, reset values and the request FSM state encoding.
package interrupt_controller_pkg;

  localparam int NUM_LINES = 8;

  // Configuration register map (cfg_addr).
  localparam logic [1:0] ADDR_MASK       = 2'd0;
  localparam logic [1:0] ADDR_PENDING    = 2'd1;
  localparam logic [1:0] ADDR_IN_SERVICE = 2'd2;
  localparam logic [1:0] ADDR_MODE       = 2'd3;

  // All lines start out edge-triggered.
  localparam logic [NUM_LINES-1:0] MODE_RESET = 8'hFF;

  // Request FSM: IDLE (no request) / ASSERT (irq held until ack).
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ASSERT = 1'b1
  } state_t;

endpackage

// File: rtl/interrupt_controller_prio.sv
// priority_encoder8: 8-bit priority encoder, lowest index wins.
//   req   - request vector
//   idx   - index of the lowest set bit of req (0 when req is empty)
//   valid - at least one bit of req is set
module priority_encoder8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    // NOTE: every combinational output gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    idx   = 3'd0;
    valid = |req;
    // Scan downward so the lowest set index is the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: 8-line prioritised interrupt controller with
// per-line mask, edge/level mode, pending and in-service tracking.
//   clk, reset         - clock, asynchronous active-low reset
//   irq_in[7:0]        - raw asynchronous interrupt lines (line 0 highest)
//   irq, vector[15:0]  - request to the CPU and handler address
//   ack, eoi           - CPU accept / end-of-handler pulses
//   cfg_we, cfg_addr, cfg_wdata, cfg_rdata - register access
//     (0 MASK, 1 PENDING (W1C), 2 IN_SERVICE (read-only), 3 MODE)
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE   = 16'h0010,
  parameter int          VECTOR_STRIDE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq_in,
  output logic        irq,
  output logic [15:0] vector,
  input  logic        ack,
  input  logic        eoi,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  output logic [7:0]  cfg_rdata
);

  logic [7:0] sync1_q, sync2_q, sync3_q;
  logic [7:0] mask_q, mask_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] in_service_q, in_service_d;
  state_t     state_q, state_d;
  logic [2:0] cur_q, cur_d;

  logic [7:0] rise, cur_onehot, ack_clr, w1c_clr, eoi_clr, elig_mask, cand;
  logic       ack_take;
  logic [2:0] cand_idx, isr_idx;
  logic       cand_valid, isr_valid;

  priority_encoder8 u_cand_enc (.req(cand),         .idx(cand_idx), .valid(cand_valid));
  priority_encoder8 u_isr_enc  (.req(in_service_q), .idx(isr_idx),  .valid(isr_valid));

  // Register and pending/in-service next-state logic.
  always_comb begin
    rise       = sync2_q & ~sync3_q;
    ack_take   = ack && (state_q == ST_ASSERT);
    cur_onehot = 8'(1) << cur_q;

    // Clears only touch edge-mode lines; a coincident rising edge wins.
    ack_clr   = ack_take ? (cur_onehot & mode_q) : 8'h00;
    w1c_clr   = (cfg_we && cfg_addr == ADDR_PENDING) ? (cfg_wdata & mode_q) : 8'h00;
    pending_d = (mode_q & ((pending_q & ~(ack_clr | w1c_clr)) | rise))
              | (~mode_q & sync2_q);

    // eoi retires the highest-priority in-service line; ack then marks cur.
    eoi_clr      = (eoi && isr_valid) ? (8'(1) << isr_idx) : 8'h00;
    in_service_d = (in_service_q & ~eoi_clr) | (ack_take ? cur_onehot : 8'h00);

    // Only lines above the highest-priority in-service line may nest.
    elig_mask = isr_valid ? ((8'(1) << isr_idx) - 8'd1) : 8'hFF;
    cand      = pending_q & mask_q & ~in_service_q & elig_mask;

    mask_d = (cfg_we && cfg_addr == ADDR_MASK) ? cfg_wdata : mask_q;
    mode_d = (cfg_we && cfg_addr == ADDR_MODE) ? cfg_wdata : mode_q;
  end

  // FSM next state; cur is latched only on entry to ASSERT so the vector
  // stays stable (no withdrawal, no preemption) until ack.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid) begin
          state_d = ST_ASSERT;
          cur_d   = cand_idx;
        end
      end
      ST_ASSERT: begin
        if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    irq    = (state_q == ST_ASSERT);
    vector = VECTOR_BASE + 16'(32'(cur_q) * 32'(VECTOR_STRIDE));
  end

  // Combinational register read.
  always_comb begin
    case (cfg_addr)
      ADDR_MASK:       cfg_rdata = mask_q;
      ADDR_PENDING:    cfg_rdata = pending_q;
      ADDR_IN_SERVICE: cfg_rdata = in_service_q;
      default:         cfg_rdata = mode_q;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the synchronizer chain work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 8'h00;
      sync2_q      <= 8'h00;
      sync3_q      <= 8'h00;
      mask_q       <= 8'h00;
      mode_q       <= MODE_RESET;
      pending_q    <= 8'h00;
      in_service_q <= 8'h00;
      state_q      <= ST_IDLE;
      cur_q        <= 3'd0;
    end else begin
      sync1_q      <= irq_in;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      state_q      <= state_d;
      cur_q        <= cur_d;
    end
  end

endmodule
